subtractor_six_serial: RTL and testbench
========================================

Name: subtractor_six_serial

Overview:
- Bit-serial 6-bit subtractor computing A - B, one bit per clock, LSB first.
- Companion to the combinational ripple adder. Used to decrement the score/level and to compare values (borrow output) in the game datapath.
- Trades area for latency: a single 1-bit full-adder cell plus shift registers.
- Uses a start/busy/done handshake.

Parameters:
- WIDTH, 6, operand and result width in bits. Cycle count scales with WIDTH.

Ports:
- clk     input   1      system clock, rising edge.
- reset   input   1      asynchronous, active-high reset.
- start   input   1      request; sampled at rising clk.
- A       input   WIDTH  minuend; sampled only on an accepted start.
- B       input   WIDTH  subtrahend; sampled only on an accepted start.
- busy    output  1      high while an operation is in progress.
- done    output  1      one-cycle pulse; result valid from this cycle onward.
- out     output  WIDTH  result, held until the next completion.
- borrow  output  1      1 when A < B (unsigned); held with out.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high; clock port clk, reset port reset.
- Reset values: state IDLE, busy=0, done=0, out=0, borrow=0. All internal shift registers, bit counter and carry are cleared.
- Arithmetic: A + ~B + 1, computed serially.
  - Carry register initialised to 1 on accept.
  - Per bit: sum = a_i ^ ~b_i ^ c; c_next = majority(a_i, ~b_i, c).
  - Final borrow = ~c after the MSB.
  - Result is unsigned modulo 2^WIDTH.
- States:
  - IDLE: busy=0. start=1 → latch A and B into shift registers, carry=1, count=0, go to RUN.
  - RUN: busy=1. Each cycle processes one bit: shift sum into a result shift register (MSB-in, shifting right) and increment count. After the bit with count=WIDTH-1, go to DONE.
  - DONE: done=1, busy=0. out and borrow are loaded from the result register and final carry on the edge entering DONE. Next edge → IDLE, or → RUN if start=1.
- Latency: start accepted at edge t → busy high after edge t. Bits are processed at edges t+1..t+WIDTH. done is high for exactly the one cycle after edge t+WIDTH (7 cycles total for WIDTH=6).
- Throughput: one result per WIDTH+1 cycles when start is held high continuously (back-to-back accept from DONE).
- start while RUN is ignored; A and B are not re-sampled. A and B may change freely after the accept edge.
- out and borrow are not disturbed during RUN; they keep the previous result until the new DONE.
- Reset asserted mid-operation: immediate return to reset values. No done pulse. The partial result is discarded.
- Operands A=B yield out=0, borrow=0. A=0, B=1 yields out=2^WIDTH-1, borrow=1.

Optional Feature:
- Macro SUB_SATURATE_EN.
- Defined: when the final borrow=1, out is forced to 0 on the DONE load; borrow still reports 1. This is used for score decrement floors.
- Undefined: out is the wrapped modulo-2^WIDTH difference. No extra logic is synthesised.

Test Plan:
- Reset, then start with A=45, B=17 → busy for 6 cycles; done pulses on cycle 7 with out=28, borrow=0; out stays 28 afterwards.
- A=5, B=9 → borrow=1; out=60 without SUB_SATURATE_EN, out=0 with it.
- A=63, B=63, then A=0, B=0 → out=0, borrow=0 both times. A=0, B=1 → out=63 (or 0 when saturating), borrow=1.
- Start A=20, B=3; pulse start with A=1, B=1 during RUN and change A/B mid-run → result is 17, done pulses exactly once, and the second start is ignored.
- Hold start high with A=10, B=4 then A=30, B=31 → done at cycles 7 and 14; results 6/0 then 63/1 (borrow).
- Assert reset at RUN bit 3 of A=50, B=8 → busy, done, out and borrow go to 0 asynchronously; no done pulse follows. A fresh start then completes normally with 42.

Source files
------------

// File: rtl/subtractor_six_serial.sv
// ---------------------------------------------------------------------------
// subtractor_six_serial
//
// Bit-serial unsigned subtractor: out = A - B, one bit per clock, LSB first.
// The difference is formed as A + ~B + 1 using a single full-adder cell: the
// carry starts at 1 and the inverted subtrahend bit feeds the cell.
// The final borrow is the inverse of the carry out of the MSB.
//
// Handshake: start is accepted in IDLE or DONE. busy is high for WIDTH
// cycles. done then pulses for one cycle, and out/borrow are updated on the
// edge that enters DONE. out/borrow hold their value until the next
// completion.
//
// Optional feature (macro SUB_SATURATE_EN): when the result borrows, out is
// loaded with 0 instead of the wrapped difference. borrow still reports 1.
//
// Ports:
//   clk     in   1      system clock, rising edge
//   reset   in   1      asynchronous, active-high reset
//   start   in   1      operation request, sampled on rising clk
//   A       in   WIDTH  minuend, sampled only on an accepted start
//   B       in   WIDTH  subtrahend, sampled only on an accepted start
//   busy    out  1      operation in progress
//   done    out  1      one-cycle completion pulse
//   out     out  WIDTH  result, held until the next completion
//   borrow  out  1      1 when A < B (unsigned), held with out
// ---------------------------------------------------------------------------
module subtractor_six_serial #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             borrow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] res_reg;
    logic [WIDTH-1:0] res_next;
    logic [WIDTH-1:0] out_reg;
    logic [WIDTH-1:0] out_next;
    logic             borrow_reg;
    logic             carry_reg;
    logic             carry_next;
    logic [CW-1:0]    count_reg;
    logic             load_ops;
    logic             step;
    logic             last_bit;
    logic             a_bit;
    logic             nb_bit;
    logic             sum_bit;

    // ---------------- serial full-adder cell ----------------
    assign a_bit      = a_reg[0];
    assign nb_bit     = ~b_reg[0];
    assign sum_bit    = a_bit ^ nb_bit ^ carry_reg;
    assign carry_next = (a_bit & nb_bit) | (a_bit & carry_reg) | (nb_bit & carry_reg);
    assign last_bit   = (count_reg == LAST_BIT);

    // The result register fills from the MSB end and shifts right. After
    // WIDTH steps, the first (LSB) sum bit has reached bit 0.
    generate
        for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_res_shift
            assign res_next[gi] = res_reg[gi + 1];
        end
    endgenerate
    assign res_next[WIDTH-1] = sum_bit;

    // On the final bit the borrow is ~carry_next.
`ifdef SUB_SATURATE_EN
    assign out_next = carry_next ? res_next : '0;
`else
    assign out_next = res_next;
`endif

    // ---------------- FSM: next state and outputs ----------------
    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        load_ops   = 1'b0;
        step       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    load_ops   = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    load_ops   = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ---------------- state and datapath registers ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            res_reg    <= '0;
            carry_reg  <= 1'b0;
            count_reg  <= '0;
            out_reg    <= '0;
            borrow_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (load_ops) begin
                a_reg     <= A;
                b_reg     <= B;
                carry_reg <= 1'b1;
                count_reg <= '0;
            end else if (step) begin
                a_reg     <= a_reg >> 1;
                b_reg     <= b_reg >> 1;
                res_reg   <= res_next;
                carry_reg <= carry_next;
                count_reg <= count_reg + CW'(1);
                if (last_bit) begin
                    out_reg    <= out_next;
                    borrow_reg <= ~carry_next;
                end
            end
        end
    end

    assign out    = out_reg;
    assign borrow = borrow_reg;

endmodule

// File: tb/tb_subtractor_six_serial.sv
// ---------------------------------------------------------------------------
// tb_subtractor_six_serial
//
// Directed vectors with hand-computed differences. The stimulus pushes the
// expected result into a queue. A monitor pops from the queue and compares
// whenever done is high. Define SUB_SATURATE_EN to build the bench for the
// saturating variant.
// ---------------------------------------------------------------------------
module tb_subtractor_six_serial;

    localparam int W = 6;

    logic         clk    = 1'b0;
    logic         reset  = 1'b1;
    logic         start  = 1'b0;
    logic [W-1:0] A      = '0;
    logic [W-1:0] B      = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] out;
    logic         borrow;

    typedef struct packed {
        logic [W-1:0] o;
        logic         b;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_vec  = 0;
    int   n_fail = 0;
    int   n_done = 0;

    always #5 clk = ~clk;

    subtractor_six_serial #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .done   (done),
        .out    (out),
        .borrow (borrow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected result from the hand-computed wrapped difference and borrow.
    function automatic exp_t mk(input int o, input bit b);
        exp_t e;
`ifdef SUB_SATURATE_EN
        e.o = b ? '0 : W'(o);
`else
        e.o = W'(o);
`endif
        e.b = b;
        return e;
    endfunction

    // Monitor: one comparison set per done pulse.
    always @(negedge clk) begin
        if (!reset && done) begin
            n_done++;
            if (q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_done: done=1 with no pending result (out=%0d)", out);
            end else begin
                mon_e = q.pop_front();
                $display("txn: out=%0d borrow=%0d (expect %0d/%0d)", out, borrow, mon_e.o, mon_e.b);
                check("out", {26'd0, out}, {26'd0, mon_e.o});
                check("borrow", {31'd0, borrow}, {31'd0, mon_e.b});
            end
        end
    end

    // Waits for done with a bounded cycle budget. n is the number of
    // negedges waited. nb is how many of them saw busy high.
    task automatic wait_done(output int n, output int nb);
        n  = 0;
        nb = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (busy) nb++;
            if (done) return;
        end
        n_vec++;
        n_fail++;
        $display("FAIL done_timeout: no done within %0d cycles", n);
    endtask

    task automatic run_op(input int a, input int b, input int o, input bit bo);
        int   n;
        int   nb;
        exp_t e;
        e = mk(o, bo);
        @(posedge clk); #1;
        A = W'(a); B = W'(b); start = 1'b1;
        q.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        A = ~A; B = ~B;             // operands must not matter after accept
        wait_done(n, nb);
        check("latency", n, 7);
        check("busy_cycles", nb, 6);
        check("busy_at_done", {31'd0, busy}, 0);
        @(negedge clk);
        check("done_pulse_width", {31'd0, done}, 0);
        check("out_hold", {26'd0, out}, {26'd0, e.o});
    endtask

    initial begin
        int n;
        int nb;
        int d0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_out", {26'd0, out}, 0);
        check("rst_borrow", {31'd0, borrow}, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Basic and boundary operands
        run_op(45, 17, 28, 1'b0);
        run_op(5, 9, 60, 1'b1);
        run_op(63, 63, 0, 1'b0);
        run_op(0, 0, 0, 1'b0);
        run_op(0, 1, 63, 1'b1);

        // start during RUN is ignored, and the operands change mid-run
        d0 = n_done;
        @(posedge clk); #1;
        A = 6'd20; B = 6'd3; start = 1'b1;
        q.push_back(mk(17, 1'b0));
        @(posedge clk); #1;
        start = 1'b0; A = 6'd0; B = 6'd0;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1; A = 6'd1; B = 6'd1;
        @(posedge clk); #1;
        start = 1'b0; A = 6'd7; B = 6'd9;
        wait_done(n, nb);
        repeat (10) @(negedge clk);
        check("done_once", n_done - d0, 1);

        // Back-to-back with start held high
        @(posedge clk); #1;
        A = 6'd10; B = 6'd4; start = 1'b1;
        q.push_back(mk(6, 1'b0));
        q.push_back(mk(63, 1'b1));
        @(posedge clk); #1;
        A = 6'd30; B = 6'd31;
        wait_done(n, nb);
        check("b2b_first_latency", n, 7);
        @(posedge clk); #1;
        start = 1'b0; A = 6'd0; B = 6'd0;
        wait_done(n, nb);
        check("b2b_second_latency", n, 7);
        check("b2b_second_busy", nb, 6);

        // Reset asserted at RUN bit 3: outputs clear at once, no done follows
        @(posedge clk); #1;
        A = 6'd50; B = 6'd8; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 0);
        check("mid_rst_done", {31'd0, done}, 0);
        check("mid_rst_out", {26'd0, out}, 0);
        check("mid_rst_borrow", {31'd0, borrow}, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        d0 = n_done;
        repeat (10) @(negedge clk);
        check("no_done_after_rst", n_done - d0, 0);
        run_op(50, 8, 42, 1'b0);

        repeat (3) @(negedge clk);
        check("queue_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
